bcd_stream_decoder: RTL and testbench
=====================================

# bcd_stream_decoder

Registered BCD-to-one-hot decoder for digit streams, the receive-side counterpart of the team's one-hot-to-BCD encoder. Accepts 4-bit BCD digits over a valid/ready handshake and emits the matching 10-bit one-hot code. Invalid codes are flagged. A 2-entry skid buffer gives full throughput with a registered `in_ready`. The block sits between a digit source (UART/keypad parser) and display or priority logic that consumes one-hot digit lines.

## Interface
- `CNT_W`, 8, width of the invalid-digit counter (≥1).

- `clk` input 1: single clock, rising edge.
- `rst` input 1: reset, synchronous and active-high.
- `in_valid` input 1: source has a digit on `in_bcd`.
- `in_ready` output 1: block can accept; driven directly from a register.
- `in_bcd` input 4: BCD digit; 0–9 valid, 10–15 invalid.
- `out_valid` output 1: `out_onehot` and `out_err` are valid.
- `out_ready` input 1: sink accepts the current output.
- `out_onehot` output 10: one-hot decode, bit *n* set for digit *n*; all zero when `out_err`=1.
- `out_err` output 1: current output came from an invalid code.
- `err_cnt` output CNT_W: saturating count of accepted invalid digits. Meaningful only when the counter feature is compiled in.

## Operation
- **Accept and present.** An input beat is accepted on a cycle with `in_valid && in_ready`. An output beat is consumed on a cycle with `out_valid && out_ready`.
- **Decode.** Decoding happens at accept time and is stored with the entry:
  - Digits 0–9: onehot = 1<<d, err = 0.
  - Digits 10–15: onehot = 10'b0, err = 1.
- **Storage.** Two entries: main (M) and skid (S). Each holds {onehot, err}.
- **States.**
  - EMPTY: no entries. `in_ready`=1, `out_valid`=0.
  - ONE: M holds data. `in_ready`=1, `out_valid`=1.
  - FULL: M and S hold data. `in_ready`=0, `out_valid`=1.
- **Transitions.** acc = input accepted, pop = output consumed.
  - EMPTY: acc → ONE (write M).
  - ONE: acc & pop → ONE (write M). acc & !pop → FULL (write S). !acc & pop → EMPTY. Otherwise hold.
  - FULL: pop → ONE (S moves to M). Otherwise hold.
- **Ordering.** Output order equals input order. No beat is dropped or duplicated.
- **Stability.** While `out_valid && !out_ready`, `out_onehot` and `out_err` hold stable.
- **In-flight behaviour.** `in_ready` does not depend combinationally on `out_ready`. The S entry absorbs the one beat accepted while the sink stalls.
- **Reset.** On `rst`=1 the block goes to EMPTY and entries are cleared.
  - `out_valid`=0, `out_onehot`=0, `out_err`=0, `in_ready`=1, `err_cnt`=0.
  - A reset mid-stream discards any buffered beats.
  - Inputs are ignored during the reset cycle.

## Timing
- Latency: 1 cycle. A beat accepted at edge *k* is visible on the outputs after edge *k*.
- Throughput: 1 beat/cycle when `out_ready` is held high.
- `in_ready` falls the cycle after entering FULL. It rises the cycle after a pop from FULL.
- `err_cnt` updates on the edge that accepts an invalid digit. The increment is coincident with the decode, not with the output pop.
- `err_cnt` saturates at 2^CNT_W−1 and never wraps.

## Configuration
- Macro: `BCD_DEC_ERR_CNT_EN`.
- Defined: `err_cnt` counts accepted invalid digits as described, with saturation.
- Undefined: no counter register is built, and `err_cnt` is tied to 0. `out_err` and all other behaviour are unchanged.

## Test plan
- **Stream all digits.** After reset, feed digits 0..9 back-to-back with `out_ready`=1.
  - Expect outputs 10'h001, 10'h002, 10'h004, … 10'h200 on consecutive cycles.
  - Expect `out_err`=0 throughout and `in_ready` constantly 1.
- **Invalid codes.** Feed 4'hA, then 4'hF, then 4'h3.
  - Expect outputs {0, err=1}, {0, err=1}, {10'h008, err=0}.
  - With the macro defined, `err_cnt`=2. Without it, `err_cnt`=0.
- **Backpressure.** Hold `out_ready`=0 and offer digits 5, 6, 7.
  - 5 and 6 are accepted. `in_ready`=0 from the next cycle, and 7 waits.
  - `out_onehot` stays 10'h020.
  - Release `out_ready`: outputs 5, 6, 7 appear in order with no loss.
- **Counter saturation.** With `CNT_W`=2 and the macro defined, feed 5 invalid digits. Expect `err_cnt` sequence 1, 2, 3, 3, 3.
- **Reset mid-operation.** Put the block in FULL holding 2 and 4, then assert `rst` for 1 cycle.
  - Next cycle: `out_valid`=0, `in_ready`=1, `err_cnt`=0.
  - A subsequent digit 9 yields 10'h200 one cycle after acceptance.

Source files
------------

// File: rtl/bcd_stream_decoder_if.sv
// Digit-stream handshake bundle for bcd_stream_decoder.
// slave: the decoder side; master: the digit source plus the one-hot sink.
interface bcd_stream_decoder_if;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] in_bcd;
    logic       out_valid;
    logic       out_ready;
    logic [9:0] out_onehot;
    logic       out_err;

    modport master (
        output in_valid, in_bcd, out_ready,
        input  in_ready, out_valid, out_onehot, out_err
    );

    modport slave (
        input  in_valid, in_bcd, out_ready,
        output in_ready, out_valid, out_onehot, out_err
    );
endinterface

// File: rtl/bcd_stream_decoder.sv
// Registered BCD-to-one-hot decoder with a 2-entry skid buffer.
// Each digit is decoded when it is accepted, and the {onehot, err} pair
// is stored with the entry. Codes 10..15 are flagged as invalid.
// Optional feature macro: BCD_DEC_ERR_CNT_EN builds a saturating counter
// of accepted invalid digits. Without it, err_cnt is tied to 0.
//
// state    | meaning
// ---------+---------------------------------------------------
// ST_EMPTY | no entries held, in_ready=1, out_valid=0
// ST_ONE   | main entry holds the head beat, in_ready=1
// ST_FULL  | main + skid hold beats, in_ready=0
module bcd_stream_decoder #(
    parameter int CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    bcd_stream_decoder_if.slave  bus,
    output logic [CNT_W-1:0]     err_cnt
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    state_t     state_q;
    state_t     state_d;
    logic       in_ready_q;
    logic       out_valid_q;
    logic [9:0] m_onehot_q;
    logic       m_err_q;
    logic [9:0] s_onehot_q;
    logic       s_err_q;

    logic       acc;
    logic       pop;
    logic [9:0] dec_onehot;
    logic       dec_err;
    logic       ld_m_in;
    logic       ld_s_in;
    logic       mv_s_m;

    assign acc = bus.in_valid && in_ready_q;
    assign pop = out_valid_q && bus.out_ready;

    assign bus.in_ready   = in_ready_q;
    assign bus.out_valid  = out_valid_q;
    assign bus.out_onehot = m_onehot_q;
    assign bus.out_err    = m_err_q;

    // Decode the incoming digit; out-of-range codes give an all-zero line set.
    always_comb begin
        dec_onehot = '0;
        dec_err    = 1'b0;
        if (bus.in_bcd <= 4'd9) begin
            dec_onehot = 10'd1 << bus.in_bcd;
        end else begin
            dec_err = 1'b1;
        end
    end

    // Next-state and entry-move selection.
    always_comb begin
        state_d = state_q;
        ld_m_in = 1'b0;
        ld_s_in = 1'b0;
        mv_s_m  = 1'b0;
        case (state_q)
            ST_EMPTY: begin
                if (acc) begin
                    state_d = ST_ONE;
                    ld_m_in = 1'b1;
                end
            end
            ST_ONE: begin
                if (acc && pop) begin
                    ld_m_in = 1'b1;
                end else if (acc) begin
                    state_d = ST_FULL;
                    ld_s_in = 1'b1;
                end else if (pop) begin
                    state_d = ST_EMPTY;
                end
            end
            ST_FULL: begin
                // in_ready is low here, so nothing can be accepted.
                if (pop) begin
                    state_d = ST_ONE;
                    mv_s_m  = 1'b1;
                end
            end
            default: begin
                state_d = ST_EMPTY;
            end
        endcase
    end

    // State register; in_ready and out_valid are flopped from the next state
    // so neither depends combinationally on out_ready.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_EMPTY;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= (state_d != ST_FULL);
            out_valid_q <= (state_d != ST_EMPTY);
        end
    end

    // Main and skid entry storage.
    always_ff @(posedge clk) begin
        if (rst) begin
            m_onehot_q <= '0;
            m_err_q    <= 1'b0;
            s_onehot_q <= '0;
            s_err_q    <= 1'b0;
        end else begin
            if (ld_m_in) begin
                m_onehot_q <= dec_onehot;
                m_err_q    <= dec_err;
            end else if (mv_s_m) begin
                m_onehot_q <= s_onehot_q;
                m_err_q    <= s_err_q;
            end
            if (ld_s_in) begin
                s_onehot_q <= dec_onehot;
                s_err_q    <= dec_err;
            end
        end
    end

`ifdef BCD_DEC_ERR_CNT_EN
    logic [CNT_W-1:0] err_cnt_q;

    // Count invalid digits at accept time, holding at all-ones.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_cnt_q <= '0;
        end else if (acc && dec_err && (err_cnt_q != {CNT_W{1'b1}})) begin
            err_cnt_q <= err_cnt_q + CNT_W'(1);
        end
    end

    assign err_cnt = err_cnt_q;
`else
    assign err_cnt = '0;
`endif

endmodule

// File: tb/tb_bcd_stream_decoder.sv
// Bench for bcd_stream_decoder: directed scenarios plus a randomized run,
// all checked against a queue-based model of the stream.
module tb_bcd_stream_decoder;

    localparam int TB_CNT_W = 2;
    localparam int MAX_CNT  = (1 << TB_CNT_W) - 1;
`ifdef BCD_DEC_ERR_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic [TB_CNT_W-1:0] err_cnt;

    bcd_stream_decoder_if bus ();

    bcd_stream_decoder #(.CNT_W(TB_CNT_W)) dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus),
        .err_cnt (err_cnt)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Model: beats held by the block, oldest first, plus the invalid count.
    int model_q[$];
    int model_cnt = 0;

    logic       exp_valid;
    logic       exp_ready;
    logic [9:0] exp_onehot;
    logic       exp_err;
    int         exp_cnt;

    function automatic logic [9:0] onehot_of(input int d);
        logic [9:0] r;
        r = '0;
        if (d < 10) r[d] = 1'b1;
        return r;
    endfunction

    function automatic void refresh_exp();
        exp_valid  = (model_q.size() > 0);
        exp_ready  = (model_q.size() < 2);
        exp_onehot = exp_valid ? onehot_of(model_q[0]) : 10'd0;
        exp_err    = exp_valid ? (model_q[0] >= 10) : 1'b0;
        exp_cnt    = CNT_EN ? model_cnt : 0;
    endfunction

    // One clock cycle of stimulus; the model advances on the same edge.
    task automatic step(input logic v, input logic [3:0] d, input logic ordy);
        bit acc, pop;
        bus.in_valid  = v;
        bus.in_bcd    = d;
        bus.out_ready = ordy;
        acc = v && (model_q.size() < 2);
        pop = (model_q.size() > 0) && ordy;
        @(posedge clk);
        if (pop) void'(model_q.pop_front());
        if (acc) begin
            model_q.push_back(int'(d));
            if (d >= 4'd10 && model_cnt < MAX_CNT) model_cnt++;
        end
        @(negedge clk);
        refresh_exp();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_bcd    = 4'd7;
        bus.out_ready = 1'b0;
        @(posedge clk);
        model_q.delete();
        model_cnt = 0;
        @(negedge clk);
        rst = 1'b0;
        bus.in_valid = 1'b0;
        refresh_exp();
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL reset out_valid got %b want 0", bus.out_valid); end
        n_cmp++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL reset in_ready got %b want 1", bus.in_ready); end
        n_cmp++; if (bus.out_onehot !== 10'd0) begin n_err++; $display("FAIL reset out_onehot got %h want 000", bus.out_onehot); end
        n_cmp++; if (bus.out_err !== 1'b0) begin n_err++; $display("FAIL reset out_err got %b want 0", bus.out_err); end
        n_cmp++; if (err_cnt !== '0) begin n_err++; $display("FAIL reset err_cnt got %0d want 0", err_cnt); end
    endtask

    task automatic test_stream_all();
        logic [9:0] want;
        do_reset();
        for (int d = 0; d < 10; d++) begin
            step(1'b1, 4'(d), 1'b1);
            want = 10'd1 << d;
            n_cmp++; if (bus.out_valid !== 1'b1 || bus.out_onehot !== want || bus.out_err !== 1'b0)
                begin n_err++; $display("FAIL stream d=%0d got v=%b oh=%h e=%b want v=1 oh=%h e=0", d, bus.out_valid, bus.out_onehot, bus.out_err, want); end
            n_cmp++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL stream in_ready d=%0d got %b want 1", d, bus.in_ready); end
        end
        step(1'b0, 4'd0, 1'b1);
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL stream drain out_valid got %b want 0", bus.out_valid); end
    endtask

    task automatic test_invalid();
        logic [3:0] digs [3];
        logic [9:0] w_oh [3];
        logic       w_er [3];
        digs = '{4'hA, 4'hF, 4'h3};
        w_oh = '{10'h000, 10'h000, 10'h008};
        w_er = '{1'b1, 1'b1, 1'b0};
        do_reset();
        for (int i = 0; i < 3; i++) begin
            step(1'b1, digs[i], 1'b1);
            n_cmp++; if (bus.out_valid !== 1'b1 || bus.out_onehot !== w_oh[i] || bus.out_err !== w_er[i])
                begin n_err++; $display("FAIL invalid i=%0d got v=%b oh=%h e=%b want v=1 oh=%h e=%b", i, bus.out_valid, bus.out_onehot, bus.out_err, w_oh[i], w_er[i]); end
        end
        n_cmp++; if (int'(err_cnt) != (CNT_EN ? 2 : 0))
            begin n_err++; $display("FAIL invalid err_cnt got %0d want %0d", err_cnt, CNT_EN ? 2 : 0); end
    endtask

    task automatic test_backpressure();
        logic [3:0] dv [7];
        logic       dr [7];
        logic       w_v [7];
        logic       w_r [7];
        logic [9:0] w_oh [7];
        dv   = '{4'd5, 4'd6, 4'd7, 4'd7, 4'd7, 4'd7, 4'd0};
        dr   = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        w_v  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        w_r  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        w_oh = '{10'h020, 10'h020, 10'h020, 10'h020, 10'h040, 10'h080, 10'h000};
        do_reset();
        for (int i = 0; i < 7; i++) begin
            step(i < 6, dv[i], dr[i]);
            n_cmp++; if (bus.out_valid !== w_v[i] || bus.in_ready !== w_r[i])
                begin n_err++; $display("FAIL backpressure ctl i=%0d got v=%b rdy=%b want v=%b rdy=%b", i, bus.out_valid, bus.in_ready, w_v[i], w_r[i]); end
            if (w_v[i]) begin
                n_cmp++; if (bus.out_onehot !== w_oh[i] || bus.out_err !== 1'b0)
                    begin n_err++; $display("FAIL backpressure data i=%0d got oh=%h e=%b want oh=%h e=0", i, bus.out_onehot, bus.out_err, w_oh[i]); end
            end
        end
    endtask

    task automatic test_saturation();
        int want;
        do_reset();
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 4'(10 + i), 1'b1);
            want = CNT_EN ? ((i + 1 < MAX_CNT) ? i + 1 : MAX_CNT) : 0;
            n_cmp++; if (int'(err_cnt) != want) begin n_err++; $display("FAIL saturation i=%0d err_cnt got %0d want %0d", i, err_cnt, want); end
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        step(1'b1, 4'd10, 1'b1);
        step(1'b1, 4'd2, 1'b0);
        step(1'b1, 4'd2, 1'b0);
        step(1'b1, 4'd4, 1'b1);
        step(1'b1, 4'd4, 1'b0);
        n_cmp++; if (bus.in_ready !== 1'b0 || bus.out_onehot !== 10'h004)
            begin n_err++; $display("FAIL midreset full got rdy=%b oh=%h want rdy=0 oh=004", bus.in_ready, bus.out_onehot); end
        do_reset();
        n_cmp++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || err_cnt !== '0)
            begin n_err++; $display("FAIL midreset after got v=%b rdy=%b cnt=%0d want v=0 rdy=1 cnt=0", bus.out_valid, bus.in_ready, err_cnt); end
        step(1'b1, 4'd9, 1'b0);
        n_cmp++; if (bus.out_valid !== 1'b1 || bus.out_onehot !== 10'h200 || bus.out_err !== 1'b0)
            begin n_err++; $display("FAIL midreset digit9 got v=%b oh=%h e=%b want v=1 oh=200 e=0", bus.out_valid, bus.out_onehot, bus.out_err); end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 3) != 0), 4'($urandom_range(0, 15)), ($urandom_range(0, 9) < 6));
            n_cmp++; if (bus.out_valid !== exp_valid || bus.in_ready !== exp_ready || int'(err_cnt) != exp_cnt)
                begin n_err++; $display("FAIL random ctl i=%0d got v=%b rdy=%b cnt=%0d want v=%b rdy=%b cnt=%0d", i, bus.out_valid, bus.in_ready, err_cnt, exp_valid, exp_ready, exp_cnt); end
            if (exp_valid) begin
                n_cmp++; if (bus.out_onehot !== exp_onehot || bus.out_err !== exp_err)
                    begin n_err++; $display("FAIL random data i=%0d got oh=%h e=%b want oh=%h e=%b", i, bus.out_onehot, bus.out_err, exp_onehot, exp_err); end
            end
        end
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_bcd    = 4'd0;
        bus.out_ready = 1'b0;
        @(negedge clk);
        test_reset();
        test_stream_all();
        test_invalid();
        test_backpressure();
        test_saturation();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout bench did not finish got running want done");
        $fatal(1, "timeout");
    end

endmodule
